// File: rtl/ysyx_22050133_axi_mem_slave.sv
// AXI4 memory responder backed by a word-addressed 64-bit array.
// Read and write channels run independent FSMs. Supports single beats
// and INCR/FIXED bursts up to 256 beats (WRAP behaves as INCR), with a
// configurable AR-to-first-R latency.
module ysyx_22050133_axi_mem_slave #(
    parameter int                        AXI_DATA_WIDTH = 64,
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_ID_WIDTH   = 4,
    parameter int                        MEM_DEPTH      = 1024,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = AXI_ADDR_WIDTH'(32'h8000_0000),
    parameter int                        RD_LATENCY     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    // AW channel
    output logic                        axi_aw_ready_o,
    input  logic                        axi_aw_valid_i,
    input  logic [AXI_ID_WIDTH-1:0]     axi_aw_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr_i,
    input  logic [7:0]                  axi_aw_len_i,
    input  logic [2:0]                  axi_aw_size_i,
    input  logic [1:0]                  axi_aw_burst_i,
    // W channel
    output logic                        axi_w_ready_o,
    input  logic                        axi_w_valid_i,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_w_data_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb_i,
    input  logic                        axi_w_last_i,
    // B channel
    input  logic                        axi_b_ready_i,
    output logic                        axi_b_valid_o,
    output logic [AXI_ID_WIDTH-1:0]     axi_b_id_o,
    output logic [1:0]                  axi_b_resp_o,
    // AR channel
    output logic                        axi_ar_ready_o,
    input  logic                        axi_ar_valid_i,
    input  logic [AXI_ID_WIDTH-1:0]     axi_ar_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr_i,
    input  logic [7:0]                  axi_ar_len_i,
    input  logic [2:0]                  axi_ar_size_i,
    input  logic [1:0]                  axi_ar_burst_i,
    // R channel
    input  logic                        axi_r_ready_i,
    output logic                        axi_r_valid_o,
    output logic [AXI_ID_WIDTH-1:0]     axi_r_id_o,
    output logic [1:0]                  axi_r_resp_o,
    output logic [AXI_DATA_WIDTH-1:0]   axi_r_data_o,
    output logic                        axi_r_last_o
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int LAT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [AXI_ADDR_WIDTH-1:0] MEM_BYTES = AXI_ADDR_WIDTH'(MEM_DEPTH * 8);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    // Offset wraps below BASE_ADDR, so one unsigned compare covers both bounds.
    function automatic logic addr_in_range(input logic [AXI_ADDR_WIDTH-1:0] addr);
        logic [AXI_ADDR_WIDTH-1:0] offset;
        offset = addr - BASE_ADDR;
        return offset < MEM_BYTES;
    endfunction

    function automatic logic [IDX_W-1:0] addr_to_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
        logic [AXI_ADDR_WIDTH-1:0] offset;
        offset = addr - BASE_ADDR;
        return IDX_W'(offset >> 3);
    endfunction

    // FIXED keeps the address; INCR and WRAP both step by the beat size.
    function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                                            input logic [2:0] size,
                                                            input logic [1:0] burst);
        if (burst == 2'b00) return addr;
        return addr + (AXI_ADDR_WIDTH'(1) << size);
    endfunction

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // ---------------- read channel state ----------------
    r_state_e                  r_state_q, r_state_d;
    logic                      ar_ready_q, ar_ready_d;
    logic                      r_valid_q, r_valid_d;
    logic [AXI_ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [1:0]                r_resp_q, r_resp_d;
    logic [AXI_DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic                      r_last_q, r_last_d;
    logic [AXI_ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [7:0]                r_len_q, r_len_d;
    logic [2:0]                r_size_q, r_size_d;
    logic [1:0]                r_burst_q, r_burst_d;
    logic [7:0]                r_beat_q, r_beat_d;
    logic [LAT_W-1:0]          r_lat_q, r_lat_d;
    logic                      rd_load;
    logic [AXI_ADDR_WIDTH-1:0] rd_load_addr;

    // ---------------- write channel state ----------------
    w_state_e                  w_state_q, w_state_d;
    logic                      aw_ready_q, aw_ready_d;
    logic                      w_ready_q, w_ready_d;
    logic                      b_valid_q, b_valid_d;
    logic [AXI_ID_WIDTH-1:0]   b_id_q, b_id_d;
    logic [1:0]                b_resp_q, b_resp_d;
    logic [AXI_ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [2:0]                w_size_q, w_size_d;
    logic [1:0]                w_burst_q, w_burst_d;
    logic                      w_err_q, w_err_d;
    logic                      w_in_range;
    logic                      mem_we;
    logic [IDX_W-1:0]          mem_widx;

    // Write length is not tracked: w_last alone ends the data phase.
    logic unused_aw_len;
    assign unused_aw_len = ^axi_aw_len_i;

    // Readies and valids are forced low while rst is high so no handshake
    // can complete in the reset cycle.
    assign axi_ar_ready_o = ar_ready_q & ~rst;
    assign axi_r_valid_o  = r_valid_q  & ~rst;
    assign axi_r_id_o     = r_id_q;
    assign axi_r_resp_o   = r_resp_q;
    assign axi_r_data_o   = r_data_q;
    assign axi_r_last_o   = r_last_q;
    assign axi_aw_ready_o = aw_ready_q & ~rst;
    assign axi_w_ready_o  = w_ready_q  & ~rst;
    assign axi_b_valid_o  = b_valid_q  & ~rst;
    assign axi_b_id_o     = b_id_q;
    assign axi_b_resp_o   = b_resp_q;

    // Read FSM next state: accept AR, count latency, stream beats back to back.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
        r_state_d    = r_state_q;
        ar_ready_d   = ar_ready_q;
        r_valid_d    = r_valid_q;
        r_id_d       = r_id_q;
        r_resp_d     = r_resp_q;
        r_data_d     = r_data_q;
        r_last_d     = r_last_q;
        r_addr_d     = r_addr_q;
        r_len_d      = r_len_q;
        r_size_d     = r_size_q;
        r_burst_d    = r_burst_q;
        r_beat_d     = r_beat_q;
        r_lat_d      = r_lat_q;
        rd_load      = 1'b0;
        rd_load_addr = r_addr_q;
        unique case (r_state_q)
            R_IDLE: begin
                ar_ready_d = 1'b1;
                if (axi_ar_valid_i && axi_ar_ready_o) begin
                    r_id_d     = axi_ar_id_i;
                    r_addr_d   = axi_ar_addr_i;
                    r_len_d    = axi_ar_len_i;
                    r_size_d   = axi_ar_size_i;
                    r_burst_d  = axi_ar_burst_i;
                    r_beat_d   = 8'd0;
                    r_lat_d    = LAT_W'(RD_LATENCY - 1);
                    ar_ready_d = 1'b0;
                    r_state_d  = R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_lat_q == '0) begin
                    rd_load      = 1'b1;
                    rd_load_addr = r_addr_q;
                    r_valid_d    = 1'b1;
                    r_last_d     = (r_beat_q == r_len_q);
                    r_state_d    = R_DATA;
                end else begin
                    r_lat_d = r_lat_q - LAT_W'(1);
                end
            end
            R_DATA: begin
                if (axi_r_ready_i && axi_r_valid_o) begin
                    if (r_beat_q == r_len_q) begin
                        r_valid_d  = 1'b0;
                        r_last_d   = 1'b0;
                        ar_ready_d = 1'b1;
                        r_state_d  = R_IDLE;
                    end else begin
                        r_addr_d     = next_addr(r_addr_q, r_size_q, r_burst_q);
                        rd_load      = 1'b1;
                        rd_load_addr = next_addr(r_addr_q, r_size_q, r_burst_q);
                        r_beat_d     = r_beat_q + 8'd1;
                        r_last_d     = ((r_beat_q + 8'd1) == r_len_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (rd_load) begin
            if (addr_in_range(rd_load_addr)) begin
                r_data_d = mem[addr_to_idx(rd_load_addr)];
                r_resp_d = RESP_OKAY;
            end else begin
                r_data_d = '0;
                r_resp_d = RESP_SLVERR;
            end
        end
    end

    // Read FSM registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_state_q  <= R_IDLE;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_id_q     <= '0;
            r_resp_q   <= 2'b00;
            r_data_q   <= '0;
            r_last_q   <= 1'b0;
            r_addr_q   <= '0;
            r_len_q    <= 8'd0;
            r_size_q   <= 3'd0;
            r_burst_q  <= 2'b00;
            r_beat_q   <= 8'd0;
            r_lat_q    <= '0;
        end else begin
            r_state_q  <= r_state_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_id_q     <= r_id_d;
            r_resp_q   <= r_resp_d;
            r_data_q   <= r_data_d;
            r_last_q   <= r_last_d;
            r_addr_q   <= r_addr_d;
            r_len_q    <= r_len_d;
            r_size_q   <= r_size_d;
            r_burst_q  <= r_burst_d;
            r_beat_q   <= r_beat_d;
            r_lat_q    <= r_lat_d;
        end
    end

    assign w_in_range = addr_in_range(w_addr_q);
    assign mem_widx   = addr_to_idx(w_addr_q);

    // Write FSM next state: accept AW, absorb W beats until w_last, return B.
    always_comb begin
        w_state_d  = w_state_q;
        aw_ready_d = aw_ready_q;
        w_ready_d  = w_ready_q;
        b_valid_d  = b_valid_q;
        b_id_d     = b_id_q;
        b_resp_d   = b_resp_q;
        w_addr_d   = w_addr_q;
        w_size_d   = w_size_q;
        w_burst_d  = w_burst_q;
        w_err_d    = w_err_q;
        mem_we     = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                aw_ready_d = 1'b1;
                if (axi_aw_valid_i && axi_aw_ready_o) begin
                    b_id_d     = axi_aw_id_i;
                    w_addr_d   = axi_aw_addr_i;
                    w_size_d   = axi_aw_size_i;
                    w_burst_d  = axi_aw_burst_i;
                    w_err_d    = 1'b0;
                    aw_ready_d = 1'b0;
                    w_ready_d  = 1'b1;
                    w_state_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (axi_w_valid_i && axi_w_ready_o) begin
                    mem_we   = w_in_range;
                    w_err_d  = w_err_q | ~w_in_range;
                    w_addr_d = next_addr(w_addr_q, w_size_q, w_burst_q);
                    if (axi_w_last_i) begin
                        w_ready_d = 1'b0;
                        b_valid_d = 1'b1;
                        b_resp_d  = (w_err_q || !w_in_range) ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (axi_b_ready_i && axi_b_valid_o) begin
                    b_valid_d  = 1'b0;
                    b_resp_d   = RESP_OKAY;
                    aw_ready_d = 1'b1;
                    w_state_d  = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q  <= W_IDLE;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_id_q     <= '0;
            b_resp_q   <= 2'b00;
            w_addr_q   <= '0;
            w_size_q   <= 3'd0;
            w_burst_q  <= 2'b00;
            w_err_q    <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
            b_id_q     <= b_id_d;
            b_resp_q   <= b_resp_d;
            w_addr_q   <= w_addr_d;
            w_size_q   <= w_size_d;
            w_burst_q  <= w_burst_d;
            w_err_q    <= w_err_d;
        end
    end

    // Byte-lane memory write; a same-edge read load still sees the old word.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately left out of reset; contents survive rst and map onto plain RAM.
        if (mem_we) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (axi_w_strb_i[k]) begin
                    mem[mem_widx][k*8 +: 8] <= axi_w_data_i[k*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050133_axi_mem_slave.sv
// Randomised self-checking bench for the AXI memory responder. A plain
// byte-addressed reference memory predicts every R beat and B response.
module tb_ysyx_22050133_axi_mem_slave;

    localparam int              DEPTH  = 1024;
    localparam int              RDL    = 2;
    localparam logic [31:0]     BASE   = 32'h8000_0000;
    localparam longint unsigned BASE_L = 64'h8000_0000;
    localparam int              TMO    = 200;

    logic        clk, rst;
    logic        aw_ready, aw_valid;
    logic [3:0]  aw_id;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        w_ready, w_valid, w_last;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        b_ready, b_valid;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        ar_ready, ar_valid;
    logic [3:0]  ar_id;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_ready, r_valid, r_last;
    logic [3:0]  r_id;
    logic [1:0]  r_resp;
    logic [63:0] r_data;

    ysyx_22050133_axi_mem_slave #(
        .AXI_DATA_WIDTH(64), .AXI_ADDR_WIDTH(32), .AXI_ID_WIDTH(4),
        .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE), .RD_LATENCY(RDL)
    ) dut (
        .clk(clk), .rst(rst),
        .axi_aw_ready_o(aw_ready), .axi_aw_valid_i(aw_valid), .axi_aw_id_i(aw_id),
        .axi_aw_addr_i(aw_addr), .axi_aw_len_i(aw_len), .axi_aw_size_i(aw_size),
        .axi_aw_burst_i(aw_burst),
        .axi_w_ready_o(w_ready), .axi_w_valid_i(w_valid), .axi_w_data_i(w_data),
        .axi_w_strb_i(w_strb), .axi_w_last_i(w_last),
        .axi_b_ready_i(b_ready), .axi_b_valid_o(b_valid), .axi_b_id_o(b_id),
        .axi_b_resp_o(b_resp),
        .axi_ar_ready_o(ar_ready), .axi_ar_valid_i(ar_valid), .axi_ar_id_i(ar_id),
        .axi_ar_addr_i(ar_addr), .axi_ar_len_i(ar_len), .axi_ar_size_i(ar_size),
        .axi_ar_burst_i(ar_burst),
        .axi_r_ready_i(r_ready), .axi_r_valid_o(r_valid), .axi_r_id_o(r_id),
        .axi_r_resp_o(r_resp), .axi_r_data_o(r_data), .axi_r_last_o(r_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] model_mem [DEPTH];
    logic [63:0] wbuf_data [256];
    logic [7:0]  wbuf_strb [256];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int k,
                                              input logic [2:0] size, input logic [1:0] burst);
        if (burst == 2'b00) return a;
        return a + 32'(k) * (32'd1 << size);
    endfunction

    function automatic bit in_range(input logic [31:0] a);
        longint unsigned x;
        x = 64'(a);
        return (x >= BASE_L) && (x < BASE_L + longint'(DEPTH) * 8);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((64'(a) - BASE_L) / 8);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                               output bit ok);
        int idx;
        ok = in_range(a);
        if (ok) begin
            idx = word_of(a);
            for (int b = 0; b < 8; b++)
                if (s[b]) model_mem[idx][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    // ---------------- write transaction ----------------
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int nbeats,
                            input logic [2:0] size, input logic [1:0] burst, input bit gaps);
        int  t;
        bit  ok;
        bit  err = 0;
        check("w_ready_idle", w_ready, 1'b0);
        aw_id = id; aw_addr = addr; aw_len = 8'(nbeats - 1); aw_size = size; aw_burst = burst;
        aw_valid = 1'b1;
        t = 0;
        while (!aw_ready && t < TMO) begin @(negedge clk); t++; end
        check("aw_ready_seen", aw_ready, 1'b1);
        @(negedge clk);
        aw_valid = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                w_valid = 1'b0;
                @(negedge clk);
            end
            w_valid = 1'b1; w_data = wbuf_data[k]; w_strb = wbuf_strb[k];
            w_last = (k == nbeats - 1);
            t = 0;
            while (!w_ready && t < TMO) begin @(negedge clk); t++; end
            if (!w_ready) begin
                check("w_ready_seen", w_ready, 1'b1);
                w_valid = 1'b0;
                return;
            end
            @(negedge clk);
            model_write(beat_addr(addr, k, size, burst), wbuf_data[k], wbuf_strb[k], ok);
            if (!ok) err = 1;
        end
        w_valid = 1'b0; w_last = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        b_ready = 1'b1;
        t = 0;
        while (!b_valid && t < TMO) begin @(negedge clk); t++; end
        check("b_valid", b_valid, 1'b1);
        check("b_id", b_id, id);
        check("b_resp", b_resp, err ? 2'b10 : 2'b00);
        @(negedge clk);
        b_ready = 1'b0;
        check("b_valid_drop", b_valid, 1'b0);
        check("aw_ready_back", aw_ready, 1'b1);
    endtask

    // ---------------- read transaction ----------------
    // rmode: 0 = r_ready always high, 1 = pattern 1,0,0,1, 2 = random.
    // stop_at >= 0 returns while beat stop_at is presented (for the reset test).
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int nbeats,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int rmode, input int stop_at);
        int          t, k, cyc, lat;
        bit          rdy;
        logic [3:0]  pat;
        logic [31:0] a;
        pat = 4'b1001;
        ar_id = id; ar_addr = addr; ar_len = 8'(nbeats - 1); ar_size = size; ar_burst = burst;
        ar_valid = 1'b1;
        t = 0;
        while (!ar_ready && t < TMO) begin @(negedge clk); t++; end
        check("ar_ready_seen", ar_ready, 1'b1);
        @(negedge clk);
        ar_valid = 1'b0;
        lat = 0;
        while (!r_valid && lat < TMO) begin @(negedge clk); lat++; end
        check("r_latency", 64'(lat), 64'(RDL));
        k = 0; cyc = 0;
        while (k < nbeats && cyc < nbeats * 8 + 50) begin
            if (k == stop_at) return;
            rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? pat[cyc % 4] : 1'($urandom_range(0, 1));
            r_ready = rdy;
            a = beat_addr(addr, k, size, burst);
            check("r_valid", r_valid, 1'b1);
            check("r_id", r_id, id);
            check("r_data", r_data, in_range(a) ? model_mem[word_of(a)] : 64'd0);
            check("r_resp", r_resp, in_range(a) ? 2'b00 : 2'b10);
            check("r_last", r_last, k == nbeats - 1);
            @(negedge clk);
            cyc++;
            if (rdy) k++;
        end
        r_ready = 1'b0;
        check("r_valid_drop", r_valid, 1'b0);
        check("ar_ready_back", ar_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          t, n, sel;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] a;

        rst = 1'b1;
        aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
        ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0;
        r_ready = 0;
        repeat (3) @(negedge clk);
        check("rst_aw_ready", aw_ready, 1'b0);
        check("rst_w_ready", w_ready, 1'b0);
        check("rst_b_valid", b_valid, 1'b0);
        check("rst_ar_ready", ar_ready, 1'b0);
        check("rst_r_valid", r_valid, 1'b0);
        check("rst_r_last", r_last, 1'b0);
        check("rst_r_data", r_data, 64'd0);
        check("rst_b_resp", b_resp, 2'b00);
        rst = 1'b0;

        // Fill the whole array with four 256-beat INCR bursts.
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 256; k++) begin
                wbuf_data[k] = {$urandom, $urandom};
                wbuf_strb[k] = 8'hFF;
            end
            do_write(4'(b), BASE + 32'(b * 2048), 256, 3'd3, 2'b01, 1'b0);
        end
        do_read(4'hA, BASE + 32'd2048, 256, 3'd3, 2'b01, 0, -1);

        // Single write then read.
        wbuf_data[0] = 64'h1122_3344_5566_7788; wbuf_strb[0] = 8'hFF;
        do_write(4'h5, 32'h8000_0010, 1, 3'd3, 2'b01, 1'b0);
        do_read(4'h9, 32'h8000_0010, 1, 3'd3, 2'b01, 0, -1);

        // INCR burst of 0..3, streamed then with backpressure.
        for (int k = 0; k < 4; k++) begin wbuf_data[k] = 64'(k); wbuf_strb[k] = 8'hFF; end
        do_write(4'h1, BASE, 4, 3'd3, 2'b01, 1'b0);
        do_read(4'h2, BASE, 4, 3'd3, 2'b01, 0, -1);
        do_read(4'h3, BASE, 4, 3'd3, 2'b01, 1, -1);

        // Partial strobe and empty strobe.
        wbuf_data[0] = 64'hFFFF_FFFF_FFFF_FFFF; wbuf_strb[0] = 8'hFF;
        do_write(4'h4, BASE + 32'd32, 1, 3'd3, 2'b01, 1'b0);
        wbuf_data[0] = 64'd0; wbuf_strb[0] = 8'h0F;
        do_write(4'h4, BASE + 32'd32, 1, 3'd3, 2'b01, 1'b0);
        do_read(4'h4, BASE + 32'd32, 1, 3'd3, 2'b01, 0, -1);
        wbuf_data[0] = 64'hDEAD_BEEF_0BAD_F00D; wbuf_strb[0] = 8'h00;
        do_write(4'h6, BASE + 32'd40, 1, 3'd3, 2'b01, 1'b0);
        do_read(4'h6, BASE + 32'd40, 1, 3'd3, 2'b01, 0, -1);

        // Out of range read below base and write just past the end.
        do_read(4'h7, 32'h7FFF_FFF8, 1, 3'd3, 2'b01, 0, -1);
        wbuf_data[0] = 64'h0123_4567_89AB_CDEF; wbuf_strb[0] = 8'hFF;
        do_write(4'h8, BASE + 32'(DEPTH * 8), 1, 3'd3, 2'b01, 1'b0);
        do_read(4'h8, BASE, 1, 3'd3, 2'b01, 0, -1);

        // FIXED burst: all beats hit one word.
        for (int k = 0; k < 3; k++) begin wbuf_data[k] = {$urandom, $urandom}; wbuf_strb[k] = 8'(1 << k); end
        do_write(4'hB, BASE + 32'd48, 3, 3'd3, 2'b00, 1'b0);
        do_read(4'hB, BASE + 32'd48, 3, 3'd3, 2'b00, 2, -1);

        // Reset during beat 2 of a 4-beat read.
        do_read(4'hC, BASE + 32'd256, 4, 3'd3, 2'b01, 0, 2);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_r_valid", r_valid, 1'b0);
        check("midrst_ar_ready", ar_ready, 1'b0);
        rst = 1'b0; r_ready = 1'b0;
        t = 0;
        while (!ar_ready && t < TMO) begin @(negedge clk); t++; end
        check("ar_ready_after_rst", ar_ready, 1'b1);
        do_read(4'hD, BASE + 32'd256, 4, 3'd3, 2'b01, 1, -1);

        // Concurrent write and read on disjoint regions.
        for (int k = 0; k < 16; k++) begin wbuf_data[k] = {$urandom, $urandom}; wbuf_strb[k] = 8'($urandom); end
        fork
            do_write(4'h7, BASE + 32'(600 * 8), 16, 3'd3, 2'b01, 1'b1);
            do_read(4'h8, BASE, 16, 3'd3, 2'b01, 2, -1);
        join
        do_read(4'h9, BASE + 32'(600 * 8), 16, 3'd3, 2'b01, 0, -1);

        // Random mix of reads and writes, including range edges.
        for (int i = 0; i < 40; i++) begin
            size  = ($urandom_range(0, 1) == 1) ? 3'd3 : 3'd2;
            burst = 2'($urandom_range(0, 2));
            n     = $urandom_range(1, 16);
            sel   = $urandom_range(0, 7);
            if (sel == 0)      a = BASE + 32'((DEPTH - 4) * 8);
            else if (sel == 1) a = BASE - 32'd16;
            else               a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 32'd8;
            if (size == 3'd2 && $urandom_range(0, 1) == 1) a = a + 32'd4;
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < n; k++) begin wbuf_data[k] = {$urandom, $urandom}; wbuf_strb[k] = 8'($urandom); end
                do_write(4'($urandom), a, n, size, burst, 1'b1);
            end else begin
                do_read(4'($urandom), a, n, size, burst, 2, -1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22050133_axi_mem_slave.md
Name: ysyx_22050133_axi_mem_slave

Overview:
AXI4 responder (slave) backed by an internal word-addressed memory array. It sits on the downstream side of the IF/MEM AXI arbiter, answering its master port in simulation and FPGA bring-up. Read and write channels are independent, each with its own FSM. The block supports single and INCR/FIXED bursts up to 256 beats, with configurable read latency.

Parameters:
AXI_DATA_WIDTH, 64, data bus width in bits; only 64 is supported.
AXI_ADDR_WIDTH, 32, address width in bits.
AXI_ID_WIDTH, 4, transaction ID width.
MEM_DEPTH, 1024, number of 64-bit words; must be a power of 2.
BASE_ADDR, 32'h8000_0000, byte address of word 0.
RD_LATENCY, 2, cycles from AR handshake to first r_valid; minimum 1.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
axi_aw_ready_o  out  1  AW ready
axi_aw_valid_i  in  1  AW valid
axi_aw_id_i / axi_aw_addr_i / axi_aw_len_i / axi_aw_size_i / axi_aw_burst_i  in  ID/ADDR/8/3/2  AW payload
axi_w_ready_o  out  1  W ready
axi_w_valid_i  in  1  W valid
axi_w_data_i / axi_w_strb_i / axi_w_last_i  in  DATA/DATA/8/1  W payload
axi_b_ready_i  in  1  B ready
axi_b_valid_o  out  1  B valid
axi_b_id_o / axi_b_resp_o  out  ID/2  B payload
axi_ar_ready_o  out  1  AR ready
axi_ar_valid_i  in  1  AR valid
axi_ar_id_i / axi_ar_addr_i / axi_ar_len_i / axi_ar_size_i / axi_ar_burst_i  in  ID/ADDR/8/3/2  AR payload
axi_r_ready_i  in  1  R ready
axi_r_valid_o  out  1  R valid
axi_r_id_o / axi_r_resp_o / axi_r_data_o / axi_r_last_o  out  ID/2/DATA/1  R payload

Behaviour:
- Reset: clk, rst (synchronous, active-high). Reset forces both FSMs to IDLE and drives every output to 0, including the readies during the rst cycle. Memory contents are not cleared. Reset mid-burst aborts the burst silently.
- Handshake rule: a transfer occurs when valid & ready are high at a posedge.
- Word index: (addr - BASE_ADDR) >> 3. An address is in range iff BASE_ADDR <= addr < BASE_ADDR + MEM_DEPTH*8.
- Address update per beat:
  - burst 2'b00 (FIXED): address unchanged.
  - burst 2'b01 or 2'b10: addr += (1 << size). WRAP is treated as INCR.
  - No 4KB-boundary check.
- Read FSM: R_IDLE -> R_WAIT -> R_DATA.
  - R_IDLE: ar_ready = 1. On AR handshake, latch id, addr, len, size, burst; beat counter = 0; load latency counter = RD_LATENCY-1; go to R_WAIT.
  - R_WAIT: ar_ready = 0. When the counter reaches 0, register r_data from the current word and go to R_DATA.
  - R_DATA: r_valid = 1, r_id = latched id, r_last = (beat == len).
  - r_resp = 2'b00 for in-range beats. Out-of-range beats give 2'b10 (SLVERR) with r_data = 0.
  - r_data/r_resp/r_last are registered and held stable while r_valid & ~r_ready. A write to the same word during a stall does not change the held beat.
  - On a non-last R handshake: advance the address, increment beat, and load the next word on the same edge, so r_valid stays high (back-to-back beats, 1 beat/cycle).
  - On the last handshake: r_valid drops and the FSM returns to R_IDLE; ar_ready is 1 the next cycle.
  - Total latency, AR handshake to first r_valid: RD_LATENCY cycles.
- Write FSM: W_IDLE -> W_DATA -> W_RESP.
  - W_IDLE: aw_ready = 1. On AW handshake, latch id, addr, size, burst; clear the error flag; go to W_DATA. w_ready is 0 in W_IDLE (W before AW is not accepted).
  - W_DATA: w_ready = 1. On each W handshake, for every strb bit k set, write byte k into the current word, then advance the address. An out-of-range beat is dropped and sets the error flag.
  - W_DATA exit: a W handshake with w_last = 1 goes to W_RESP. The AW len is not checked against the w_last count.
  - W_RESP: b_valid = 1, b_id = latched id, b_resp = error ? 2'b10 : 2'b00. On B handshake, return to W_IDLE.
- Simultaneous read and write:
  - Both channels run concurrently.
  - Same-cycle write and read-data load of the same word: the read gets the old value; the new value is visible from the next load.
- strb = 0: the beat is accepted with no memory change.
- len = 255: 256 beats; the beat counter is 8 bits, so len+1 must not overflow the comparison.

Test Plan:
- Single write then read: AW addr 0x8000_0010, W data 0x1122334455667788, strb 0xFF, last -> b_valid with resp 0, id echoed. AR same addr, len 0 -> r_valid exactly 2 cycles after AR handshake, data 0x1122334455667788, r_last = 1.
- INCR read burst: preload words 0..3 with 0,1,2,3; AR addr BASE, len 3, size 3, r_ready always 1 -> 4 consecutive r_valid beats with data 0,1,2,3; r_last only on the 4th; ar_ready high the next cycle.
- Backpressure: same burst with r_ready toggling 1,0,0,1,... -> data held stable during stalls, no beat lost or duplicated, order 0..3.
- Partial strobe: word = 0xFFFF_FFFF_FFFF_FFFF, write 0 with strb 0x0F -> readback 0xFFFF_FFFF_0000_0000.
- Out of range: AR addr 0x7FFF_FFF8 -> r_resp 2'b10, data 0. Write to BASE + MEM_DEPTH*8 -> b_resp 2'b10, memory unchanged.
- Reset mid-burst: assert rst during beat 2 of a len-3 read -> r_valid 0 the next cycle, ar_ready 1 after rst deasserts, a new read returns correct data.
